sram_port_arbiter: RTL and testbench

- Shares the single 32x32 SRAM macro between two requesters: port 0 (UART command controller) and port 1 (on-chip fill/self-test engine or a second host).
- Round-robin arbitration with a req/gnt handshake; exactly one SRAM access in flight at a time.
- Sequences the active-low chip-select and write-enable, and returns read data with a one-cycle valid strobe.
- Sits between the requesters and the SRAM macro pins.

---
 rtl/sram_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported SRAM macro.
// One access is in flight at a time: a write occupies one ACC cycle, a read
// runs ACC -> RDWAIT -> RESP, with read data returned to the winning port
// together with a one-cycle valid strobe. Every output comes from a register.
module sram_port_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  // port 0 (UART command controller)
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  // port 1 (fill / self-test engine or second host)
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  // SRAM macro pins
  output logic              csb_n,
  output logic              we_n,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_data_in,
  input  logic [DATA_W-1:0] sram_data_out,
  // status
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC    = 2'd1,
    RDWAIT = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e              state_q;
  logic                last_q;      // port that won the most recent access
  logic                win_q;       // port owning the access in flight
  logic                we_q;        // access in flight is a write
  logic                csb_n_q;
  logic                we_n_q;
  logic [ADDR_W-1:0]   sram_addr_q;
  logic [DATA_W-1:0]   sram_data_in_q;
  logic                p0_gnt_q;
  logic                p1_gnt_q;
  logic                p0_rvalid_q;
  logic                p1_rvalid_q;
  logic [DATA_W-1:0]   p0_rdata_q;
  logic [DATA_W-1:0]   p1_rdata_q;
  logic                busy_q;

  // Arbitration result and the winner's command, valid while in IDLE.
  logic                any_req;
  logic                win_d;
  logic                we_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   wdata_d;

  // Pick the winner: a lone requester wins; on a tie the port that did not
  // go last wins, which bounds any wait to one foreign access.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    any_req = p0_req | p1_req;
    win_d   = 1'b0;
    if (p0_req && p1_req) begin
      win_d = ~last_q;
    end else if (p1_req) begin
      win_d = 1'b1;
    end
    we_d    = win_d ? p1_we    : p0_we;
    addr_d  = win_d ? p1_addr  : p0_addr;
    wdata_d = win_d ? p1_wdata : p0_wdata;
  end

  // Access sequencer: registers the winner's command, drives the SRAM pins
  // for one cycle, and routes returned read data to the owning port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      last_q         <= 1'b1;
      win_q          <= 1'b0;
      we_q           <= 1'b0;
      csb_n_q        <= 1'b1;
      we_n_q         <= 1'b1;
      sram_addr_q    <= '0;
      sram_data_in_q <= '0;
      p0_gnt_q       <= 1'b0;
      p1_gnt_q       <= 1'b0;
      p0_rvalid_q    <= 1'b0;
      p1_rvalid_q    <= 1'b0;
      p0_rdata_q     <= '0;
      p1_rdata_q     <= '0;
      busy_q         <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so the pulse
      // defaults below are simply overridden by later assignments in the case.
      p0_gnt_q    <= 1'b0;
      p1_gnt_q    <= 1'b0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q        <= ACC;
            busy_q         <= 1'b1;
            win_q          <= win_d;
            we_q           <= we_d;
            sram_addr_q    <= addr_d;
            sram_data_in_q <= wdata_d;
            csb_n_q        <= 1'b0;
            we_n_q         <= ~we_d;
            p0_gnt_q       <= ~win_d;
            p1_gnt_q       <= win_d;
          end
        end

        ACC: begin
          // Address and write data stay on the pins; only the strobes drop.
          csb_n_q <= 1'b1;
          we_n_q  <= 1'b1;
          last_q  <= win_q;
          if (we_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= RDWAIT;
          end
        end

        RDWAIT: begin
          // The macro presents read data this cycle; each port keeps its own copy.
          if (win_q) begin
            p1_rdata_q  <= sram_data_out;
            p1_rvalid_q <= 1'b1;
          end else begin
            p0_rdata_q  <= sram_data_out;
            p0_rvalid_q <= 1'b1;
          end
          state_q <= RESP;
        end

        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign csb_n        = csb_n_q;
  assign we_n         = we_n_q;
  assign sram_addr    = sram_addr_q;
  assign sram_data_in = sram_data_in_q;
  assign p0_gnt       = p0_gnt_q;
  assign p1_gnt       = p1_gnt_q;
  assign p0_rvalid    = p0_rvalid_q;
  assign p1_rvalid    = p1_rvalid_q;
  assign p0_rdata     = p0_rdata_q;
  assign p1_rdata     = p1_rdata_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter. Two requester models drive the ports; a
// transaction-level timeline (grant times, arbiter-free time, shadow memory)
// predicts every output each cycle. An SRAM behavioural model sits on the pins.
module tb_sram_port_arbiter;

  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int MAXC = 4096;

  logic          clk;
  logic          rst_n;
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          csb_n, we_n, busy;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_data_in, sram_data_out;

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .csb_n(csb_n), .we_n(we_n), .sram_addr(sram_addr),
    .sram_data_in(sram_data_in), .sram_data_out(sram_data_out), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SRAM macro: synchronous, read data appears the cycle after the access.
  logic [DW-1:0] sram_mem [32];
  always @(posedge clk) begin
    if (!csb_n) begin
      if (!we_n) sram_mem[sram_addr] <= sram_data_in;
      else       sram_data_out       <= sram_mem[sram_addr];
    end
  end

  // Counters
  int n_vec = 0;
  int n_err = 0;

  // Reference timeline
  int            cyc;
  int            next_idle;
  int            last_w;
  int            exp_gnt     [MAXC];
  int            exp_rv      [MAXC];
  logic [DW-1:0] exp_rv_data [MAXC];
  bit            exp_acc     [MAXC];
  bit            exp_acc_we  [MAXC];
  logic [AW-1:0] exp_acc_addr[MAXC];
  logic [DW-1:0] exp_acc_wdata[MAXC];
  logic [DW-1:0] shadow [32];
  logic [DW-1:0] cur_rdata [2];
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_wdata;

  // Requester models
  bit            pend [2];
  bit            rq_we [2];
  logic [AW-1:0] rq_addr [2];
  logic [DW-1:0] rq_wdata [2];
  bit            cont [2];
  bit            rnd_mode;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic issue(input int p, input bit we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata);
    pend[p]     = 1'b1;
    rq_we[p]    = we;
    rq_addr[p]  = addr;
    rq_wdata[p] = wdata;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
    return AW'($urandom_range(0, 31));
  endfunction

  task automatic drive();
    p0_req = pend[0]; p0_we = rq_we[0]; p0_addr = rq_addr[0]; p0_wdata = rq_wdata[0];
    p1_req = pend[1]; p1_we = rq_we[1]; p1_addr = rq_addr[1]; p1_wdata = rq_wdata[1];
  endtask

  task automatic check_cycle();
    if (exp_rv[cyc] == 1) cur_rdata[0] = exp_rv_data[cyc];
    if (exp_rv[cyc] == 2) cur_rdata[1] = exp_rv_data[cyc];
    if (exp_acc[cyc]) begin
      last_addr  = exp_acc_addr[cyc];
      last_wdata = exp_acc_wdata[cyc];
    end
    check("p0_gnt",       32'(p0_gnt),    32'(exp_gnt[cyc] == 1));
    check("p1_gnt",       32'(p1_gnt),    32'(exp_gnt[cyc] == 2));
    check("p0_rvalid",    32'(p0_rvalid), 32'(exp_rv[cyc] == 1));
    check("p1_rvalid",    32'(p1_rvalid), 32'(exp_rv[cyc] == 2));
    check("p0_rdata",     p0_rdata,       cur_rdata[0]);
    check("p1_rdata",     p1_rdata,       cur_rdata[1]);
    check("csb_n",        32'(csb_n),     32'(!exp_acc[cyc]));
    check("we_n",         32'(we_n),      32'(!(exp_acc[cyc] && exp_acc_we[cyc])));
    check("sram_addr",    32'(sram_addr), 32'(last_addr));
    check("sram_data_in", sram_data_in,   last_wdata);
    check("busy",         32'(busy),      32'(cyc < next_idle));
  endtask

  // Transaction-level prediction from the requests visible this cycle.
  task automatic model_update();
    int w;
    int g;
    if (cyc >= next_idle && (pend[0] || pend[1])) begin
      if (pend[0] && pend[1]) w = 1 - last_w;
      else                    w = pend[0] ? 0 : 1;
      last_w = w;
      g = cyc + 1;
      exp_gnt[g]       = w + 1;
      exp_acc[g]       = 1'b1;
      exp_acc_we[g]    = rq_we[w];
      exp_acc_addr[g]  = rq_addr[w];
      exp_acc_wdata[g] = rq_wdata[w];
      if (rq_we[w]) begin
        shadow[rq_addr[w]] = rq_wdata[w];
        next_idle = g + 1;
      end else begin
        exp_rv[g + 2]      = w + 1;
        exp_rv_data[g + 2] = shadow[rq_addr[w]];
        next_idle = g + 3;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      if (exp_gnt[cyc] != p + 1) begin
        if (pend[p]) begin
          if (rnd_mode && $urandom_range(0, 15) == 0) pend[p] = 1'b0;
        end else if (cont[p]) begin
          issue(p, 1'b0, rand_addr(), $urandom);
        end else if (rnd_mode && $urandom_range(0, 2) == 0) begin
          issue(p, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
        end
      end
    end
    drive();
    @(negedge clk);
    check_cycle();
    model_update();
    for (int p = 0; p < 2; p++)
      if (exp_gnt[cyc] == p + 1) pend[p] = 1'b0;
    cyc++;
  endtask

  task automatic run_quiet();
    int n = 0;
    while ((pend[0] || pend[1] || cyc < next_idle + 1) && n < 64) begin
      step();
      n++;
    end
    if (n >= 64) begin
      n_vec++;
      n_err++;
      $display("FAIL quiet_timeout at cycle %0d: arbiter still busy after %0d cycles", cyc, n);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_csb_n"},  32'(csb_n),     32'd1);
    check({tag, "_we_n"},   32'(we_n),      32'd1);
    check({tag, "_busy"},   32'(busy),      32'd0);
    check({tag, "_gnt"},    32'({p0_gnt, p1_gnt}),       32'd0);
    check({tag, "_rvalid"}, 32'({p0_rvalid, p1_rvalid}), 32'd0);
    check({tag, "_p0_rdata"}, p0_rdata, 32'd0);
    check({tag, "_p1_rdata"}, p1_rdata, 32'd0);
    check({tag, "_addr"},   32'(sram_addr), 32'd0);
    check({tag, "_wdata"},  sram_data_in,   32'd0);
  endtask

  task automatic model_reset();
    for (int i = cyc; i < cyc + 16; i++) begin
      exp_gnt[i] = 0;
      exp_rv[i]  = 0;
      exp_acc[i] = 1'b0;
    end
    cyc        = cyc + 4;
    next_idle  = cyc;
    last_w     = 1;
    cur_rdata[0] = '0;
    cur_rdata[1] = '0;
    last_addr  = '0;
    last_wdata = '0;
  endtask

  initial begin
    logic [DW-1:0] v;
    bit found;
    for (int i = 0; i < 32; i++) begin
      v = $urandom;
      sram_mem[i] <= v;
      shadow[i]    = v;
    end
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; cont[p] = 1'b0; rq_we[p] = 1'b0;
      rq_addr[p] = '0; rq_wdata[p] = '0;
    end
    rnd_mode = 1'b0;
    drive();
    sram_data_out = '0;
    cyc = 0;
    model_reset();
    cyc = 0;
    next_idle = 0;

    // Reset values
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Simultaneous reads right after reset: port 0 first, then port 1.
    issue(0, 1'b0, 5'd3, 32'hA5A5_0003);
    issue(1, 1'b0, 5'd9, 32'h5A5A_0009);
    run_quiet();
    check("tie_p0_rdata", p0_rdata, shadow[3]);
    check("tie_p1_rdata", p1_rdata, shadow[9]);

    // Port 0 write then read of address 5.
    issue(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    run_quiet();
    issue(0, 1'b0, 5'd5, 32'h0);
    run_quiet();
    check("wr_rd_p0_rdata", p0_rdata, 32'hDEAD_BEEF);

    // Both ports streaming reads: grants must alternate.
    cont[0] = 1'b1;
    cont[1] = 1'b1;
    repeat (34) step();
    cont[0] = 1'b0;
    cont[1] = 1'b0;
    run_quiet();

    // Port 1 writes 31; port 0 asks for 31 during port 1's access cycle.
    issue(1, 1'b1, 5'd31, 32'h1234_5678);
    step();
    issue(0, 1'b0, 5'd31, 32'h0);
    run_quiet();
    check("cross_port_rdata", p0_rdata, 32'h1234_5678);

    // Reset while a port 1 read sits in RDWAIT.
    issue(1, 1'b0, 5'd7, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (exp_gnt[cyc - 1] == 2) found = 1'b1;
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    drive();
    #1 check_reset_outputs("midread_reset");
    @(negedge clk);
    @(posedge clk);
    #1 check_reset_outputs("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (6) step();
    issue(0, 1'b0, 5'd7, 32'h0);
    issue(1, 1'b0, 5'd5, 32'h0);
    run_quiet();

    // Twenty quiet cycles.
    repeat (20) step();

    // Randomised traffic.
    rnd_mode = 1'b1;
    repeat (1500) step();
    rnd_mode = 1'b0;
    run_quiet();
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
